// File: rtl/ppe_sync.sv
// ppe_sync -- partial-sum processing element for the SNN convolution datapath.
//
// Holds one kernel row of signed weights. For every received row of 1-bit
// spikes, it emits one psum packet per sliding window to the SPEs, cycling
// through destinations. It then asks IMEM for the next row while the timestep
// still has rows outstanding.
//
// Packet layout (in_data / out_data): [32:29] addr, [28:25] opcode, [24:0] data.
//
// Ports
//   clk         clock
//   reset       asynchronous, active-high reset
//   in_valid    inbound packet valid
//   in_ready    block can accept a packet (high only in IDLE)
//   in_data     inbound packet
//   out_valid   outbound packet valid
//   out_ready   downstream accepts
//   out_data    outbound packet (registered)
//   busy        high in any state other than IDLE
//   illegal_op  sticky: an unknown opcode was received
//
// Build option
//   PPE_SAT_EN  when defined, the window sum is clamped to the SUM_WIDTH range.
//               When undefined, it is truncated (two's-complement wrap).

module ppe_sync #(
  parameter int FILTER_SIZE  = 5,
  parameter int IFMAP_SIZE   = 25,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SUM_WIDTH    = 13,
  parameter int NUM_SPE      = 5,
  parameter int ROWS_PER_TS  = 5,
  parameter int PE_ID        = 0,
  parameter int IMEM_ID      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_data,
  output logic        busy,
  output logic        illegal_op
);

  localparam int WPP     = 25 / WEIGHT_WIDTH;
  localparam int OUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
  localparam int FULL_W  = WEIGHT_WIDTH + $clog2(FILTER_SIZE) + 1;
  localparam int WIN_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  localparam logic [3:0] OP_WEIGHT = 4'd0;
  localparam logic [3:0] OP_INPUT  = 4'd1;
  localparam logic [3:0] OP_WCLR   = 4'd2;
  localparam logic [3:0] OP_TSDONE = 4'd15;

  localparam logic [7:0]       FS8       = 8'(FILTER_SIZE);
  localparam logic [7:0]       WPP8      = 8'(WPP);
  localparam logic [7:0]       ROWS8     = 8'(ROWS_PER_TS);
  localparam logic [3:0]       DEST_LAST = 4'(NUM_SPE - 1);
  localparam logic [3:0]       IMEM_A    = 4'(IMEM_ID);
  localparam logic [3:0]       PE_OP     = 4'(PE_ID);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(OUT_DIM - 1);

`ifdef PPE_SAT_EN
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (SUM_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (SUM_WIDTH - 1));
`endif

  typedef enum logic [1:0] {S_IDLE, S_PSUM, S_REQ} state_t;

  state_t r_state, w_state_nxt;

  logic signed [WEIGHT_WIDTH-1:0] r_w [FILTER_SIZE];
  logic [7:0]            r_wptr;
  logic [7:0]            r_row_cnt;
  logic [7:0]            r_ts;
  logic [3:0]            r_dest;
  logic [WIN_W-1:0]      r_win;
  logic [IFMAP_SIZE-1:0] r_row;
  logic                  r_out_valid;
  logic [32:0]           r_out_data;
  logic                  r_illegal;

  logic [3:0]                   w_op;
  logic                         w_accept;
  logic                         w_out_hs;
  logic                         w_last_win;
  logic                         w_req_due;
  logic [3:0]                   w_dest_inc;
  logic [IFMAP_SIZE-1:0]        w_src_row;
  logic [WIN_W-1:0]             w_src_win;
  logic [IFMAP_SIZE-1:0]        w_shift;
  logic signed [FULL_W-1:0]     w_sum_full;
  logic signed [31:0]           w_sum32;
  logic signed [31:0]           w_red32;
  logic signed [SUM_WIDTH-1:0]  w_sum_red;
  logic [24:0]                  w_psum25;
  logic [32:0]                  w_psum_pkt;
  logic [32:0]                  w_req_pkt;
  logic                         w_unused_bits;

  assign w_op       = in_data[28:25];
  assign w_accept   = in_valid & in_ready;
  assign w_out_hs   = r_out_valid & out_ready;
  assign w_last_win = (r_win == WIN_LAST);
  // row_cnt already counts the row in flight, so this asks "are more rows due?"
  assign w_req_due  = (r_row_cnt < ROWS8);
  assign w_dest_inc = (r_dest == DEST_LAST) ? 4'd0 : r_dest + 4'd1;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept && w_op == OP_INPUT) w_state_nxt = S_PSUM;
      S_PSUM: if (w_out_hs && w_last_win)       w_state_nxt = w_req_due ? S_REQ : S_IDLE;
      S_REQ:  if (w_out_hs)                     w_state_nxt = S_IDLE;
      default:                                  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == S_IDLE);
    busy       = (r_state != S_IDLE);
    out_valid  = r_out_valid;
    out_data   = r_out_data;
    illegal_op = r_illegal;
  end

  // ------------------------------------------------------ window datapath
  // Window 0 is computed straight from in_data on the INPUT edge so that the
  // first psum is valid right after acceptance. Later windows come from the
  // stored row and the index that follows the one being handshaken.
  assign w_src_row = (r_state == S_IDLE) ? in_data[IFMAP_SIZE-1:0] : r_row;
  assign w_src_win = (r_state == S_IDLE) ? '0 : r_win + WIN_W'(1);
  assign w_shift   = w_src_row >> w_src_win;

  always_comb begin
    w_sum_full = '0;
    for (int k = 0; k < FILTER_SIZE; k++) begin
      if (w_shift[k])
        w_sum_full = w_sum_full +
                     {{(FULL_W-WEIGHT_WIDTH){r_w[k][WEIGHT_WIDTH-1]}}, r_w[k]};
    end
  end

  // Widen first: SUM_WIDTH may exceed the natural full-sum width.
  assign w_sum32 = 32'(w_sum_full);

`ifdef PPE_SAT_EN
  always_comb begin
    w_red32 = w_sum32;
    if (w_sum32 > SAT_MAX)      w_red32 = SAT_MAX;
    else if (w_sum32 < SAT_MIN) w_red32 = SAT_MIN;
  end
`else
  assign w_red32 = w_sum32;
`endif

  assign w_sum_red = w_red32[SUM_WIDTH-1:0];
  assign w_psum25  = 25'(w_sum_red);

  // The first window goes to the current dest; later ones go to the dest that
  // the handshake in progress advances to.
  assign w_psum_pkt = {(r_state == S_IDLE) ? r_dest : w_dest_inc, OP_WEIGHT, w_psum25};
  assign w_req_pkt  = {IMEM_A, PE_OP, 17'd0, r_ts};

  // Inbound addr is not needed, and the upper sum bits are dropped on purpose
  // when truncating.
  assign w_unused_bits = ^{in_data[32:29], w_red32};

  // -------------------------------------------------------- weight store
  // Weights are not reset. Each lane lands at wptr+i; anything past the
  // filter is dropped.
  always_ff @(posedge clk) begin
    if (w_accept && w_op == OP_WEIGHT) begin
      for (int k = 0; k < FILTER_SIZE; k++) begin
        for (int i = 0; i < WPP; i++) begin
          if (r_wptr + 8'(i) == 8'(k))
            r_w[k] <= in_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
      end
    end
  end

  // ------------------------------------------------------- control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_row_cnt   <= '0;
      r_ts        <= '0;
      r_dest      <= '0;
      r_win       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_illegal   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            unique case (w_op)
              OP_WEIGHT: begin
                // Stop advancing once past the filter, so the pointer cannot wrap.
                if (r_wptr < FS8) r_wptr <= r_wptr + WPP8;
              end
              OP_INPUT: begin
                r_row       <= in_data[IFMAP_SIZE-1:0];
                r_win       <= '0;
                r_out_valid <= 1'b1;
                r_out_data  <= w_psum_pkt;
                if (r_row_cnt != 8'hFF) r_row_cnt <= r_row_cnt + 8'd1;
              end
              OP_WCLR: r_wptr <= '0;
              OP_TSDONE: begin
                r_row_cnt <= '0;
                r_dest    <= '0;
                r_ts      <= r_ts + 8'd1;
              end
              default: r_illegal <= 1'b1;
            endcase
          end
        end
        S_PSUM: begin
          if (w_out_hs) begin
            r_dest <= w_dest_inc;
            if (w_last_win) begin
              if (w_req_due) r_out_data  <= w_req_pkt;
              else           r_out_valid <= 1'b0;
            end else begin
              r_win      <= r_win + WIN_W'(1);
              r_out_data <= w_psum_pkt;
            end
          end
        end
        S_REQ: begin
          if (w_out_hs) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule
